// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
package aes_sched_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_KEY_W   = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      RESP   = 2'd3
   } sched_state_e;

endpackage

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority picker. Scans upward from
// i_ptr with wrap-around and grants the first asserted request.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   localparam logic [IW:0] N_L = (IW+1)'(N);

   logic [IW:0]   w_pos;
   logic [IW-1:0] w_sel;

   // Walk the N candidate positions starting at the pointer; first hit wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_pos   = '0;
      w_sel   = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_pos >= N_L) begin
            w_pos = w_pos - N_L;
         end
         w_sel = w_pos[IW-1:0];
         if (!o_any && i_req[w_sel]) begin
            o_any          = 1'b1;
            o_grant[w_sel] = 1'b1;
            o_idx          = w_sel;
         end
      end
   end

endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: shares one iterative AES-256 encrypt core between
// NUM_REQ requesters. One job in flight at a time; results are returned with
// the owning requester's ID.
// Optional watchdog on the BUSY wait: define AES_SCHED_TIMEOUT_EN.
module aes_job_scheduler
   import aes_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int TIMEOUT = 256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [AES_BLOCK_W*NUM_REQ-1:0] req_data,
   input  logic [AES_KEY_W*NUM_REQ-1:0]   req_key,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [ID_W-1:0]                resp_id,
   output logic [AES_BLOCK_W-1:0]         resp_data,
   output logic                           resp_err,
   output logic                           busy,
   output logic                           core_start,
   output logic [AES_BLOCK_W-1:0]         core_data_in,
   output logic [AES_KEY_W-1:0]           core_key,
   input  logic [AES_BLOCK_W-1:0]         core_data_out,
   input  logic                           core_done
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_param_check
      $error("aes_job_scheduler: NUM_REQ must be 2..8 and TIMEOUT at least 2");
   end

   sched_state_e            r_state;
   sched_state_e            w_state_next;
   logic [ID_W-1:0]         r_rr_ptr;
   logic [ID_W-1:0]         r_resp_id;
   logic [AES_BLOCK_W-1:0]  r_resp_data;
   logic [AES_BLOCK_W-1:0]  r_core_data_in;
   logic [AES_KEY_W-1:0]    r_core_key;
   logic [NUM_REQ-1:0]      w_grant;
   logic [ID_W-1:0]         w_idx;
   logic                    w_any;
   logic                    w_accept;
   logic                    w_timeout;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Grant is only offered in IDLE, so a selected valid is a completed handshake.
   assign w_accept = (r_state == IDLE) && w_any;

`ifdef AES_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_resp_err;

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign resp_err  = r_resp_err;

   // Watchdog: cleared while launching, counts every BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == LAUNCH) begin
         r_cnt <= '0;
      end else if (r_state == BUSY) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Error flag: core completion takes priority over a coincident timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_err <= 1'b0;
      end else if (r_state == BUSY) begin
         if (core_done) begin
            r_resp_err <= 1'b0;
         end else if (w_timeout) begin
            r_resp_err <= 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign resp_err  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_state_next = r_state;
      req_ready    = '0;
      resp_valid   = 1'b0;
      busy         = 1'b1;
      core_start   = 1'b0;
      case (r_state)
         IDLE: begin
            busy      = 1'b0;
            req_ready = w_grant;
            if (w_any) begin
               w_state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            core_start   = 1'b1;
            w_state_next = BUSY;
         end
         BUSY: begin
            if (core_done || w_timeout) begin
               w_state_next = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Job capture on accept and result capture at the end of BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr       <= '0;
         r_resp_id      <= '0;
         r_resp_data    <= '0;
         r_core_data_in <= '0;
         r_core_key     <= '0;
      end else begin
         if (w_accept) begin
            r_core_data_in <= req_data[w_idx*AES_BLOCK_W +: AES_BLOCK_W];
            r_core_key     <= req_key[w_idx*AES_KEY_W +: AES_KEY_W];
            r_resp_id      <= w_idx;
            r_rr_ptr       <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
         end
         if (r_state == BUSY) begin
            if (core_done) begin
               r_resp_data <= core_data_out;
            end else if (w_timeout) begin
               r_resp_data <= '0;
            end
         end
      end
   end

   assign resp_id      = r_resp_id;
   assign resp_data    = r_resp_data;
   assign core_data_in = r_core_data_in;
   assign core_key     = r_core_key;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Testbench for aes_job_scheduler with a simple behavioural AES core stand-in.
// Define AES_SCHED_TIMEOUT_EN to build the watchdog variant (TIMEOUT = 16).
module tb_aes_job_scheduler;
   import aes_sched_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;
`ifdef AES_SCHED_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 256;
`endif

   localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [128*N-1:0] req_data;
   logic [256*N-1:0] req_key;
   logic             resp_valid;
   logic             resp_ready;
   logic [IW-1:0]    resp_id;
   logic [127:0]     resp_data;
   logic             resp_err;
   logic             busy;
   logic             core_start;
   logic [127:0]     core_data_in;
   logic [255:0]     core_key;
   logic [127:0]     core_data_out;
   logic             core_done;

   logic [127:0] pt [N];
   logic [255:0] ky [N];

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ptr  = 0;

   // core stand-in controls
   logic         core_hang = 1'b0;
   int           core_lat  = 3;
   logic         inj_done  = 1'b0;
   logic [127:0] inj_data  = '0;
   logic         mdl_done;
   logic [127:0] mdl_data;
   logic         mdl_active;
   int           mdl_cnt;

   aes_job_scheduler #(
      .NUM_REQ (N),
      .ID_W    (IW),
      .TIMEOUT (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_data      (req_data),
      .req_key       (req_key),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_id       (resp_id),
      .resp_data     (resp_data),
      .resp_err      (resp_err),
      .busy          (busy),
      .core_start    (core_start),
      .core_data_in  (core_data_in),
      .core_key      (core_key),
      .core_data_out (core_data_out),
      .core_done     (core_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      req_key  = '0;
      for (int i = 0; i < N; i++) begin
         req_data[128*i +: 128] = pt[i];
         req_key[256*i +: 256]  = ky[i];
      end
   end

   // Stand-in cipher: the real FIPS vector, otherwise an easily predicted mix.
   function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [255:0] k);
      if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
      return d ^ k[255:128] ^ {k[63:0], k[127:64]};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] rand256();
      return {rand128(), rand128()};
   endfunction

   // Round-robin reference: first valid at or after the pointer, wrapping.
   function automatic int model_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   assign core_done     = mdl_done | inj_done;
   assign core_data_out = inj_done ? inj_data : mdl_data;

   // Core stand-in: done pulses core_lat cycles after the first BUSY cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_done   <= 1'b0;
         mdl_data   <= '0;
         mdl_active <= 1'b0;
         mdl_cnt    <= 0;
      end else begin
         mdl_done <= 1'b0;
         if (core_start) begin
            mdl_active <= !core_hang;
            mdl_cnt    <= core_lat;
         end else if (mdl_active) begin
            if (mdl_cnt <= 1) begin
               mdl_active <= 1'b0;
               mdl_done   <= 1'b1;
               mdl_data   <= core_fn(core_data_in, core_key);
            end else begin
               mdl_cnt <= mdl_cnt - 1;
            end
         end
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (|req_ready) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_resp(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (resp_valid) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      req_valid  = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         pt[i] = rand128();
         ky[i] = rand256();
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_checks++; if (resp_id !== '0) begin n_fail++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
      n_checks++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start: got %b want 0", core_start); end
      n_checks++; if (core_data_in !== '0) begin n_fail++; $display("FAIL reset_core_data_in: got %h want 0", core_data_in); end
      n_checks++; if (core_key !== '0) begin n_fail++; $display("FAIL reset_core_key: got %h want 0", core_key); end
      rst_n = 1'b1;
      exp_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_fips();
      bit ok;
      int g;
      pt[2] = FIPS_PT;
      ky[2] = FIPS_KEY;
      req_valid  = 4'b0100;
      resp_ready = 1'b1;
      core_lat   = 5;
      wait_ready(ok);
      g = model_pick(req_valid, exp_ptr);
      n_checks++; if (!ok || req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL fips_grant: got %b want %b", req_ready, 4'(1 << g)); end
      exp_ptr = (g + 1) % N;
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL fips_start: got %b want 1", core_start); end
      n_checks++; if (core_data_in !== FIPS_PT) begin n_fail++; $display("FAIL fips_core_data: got %h want %h", core_data_in, FIPS_PT); end
      n_checks++; if (core_key !== FIPS_KEY) begin n_fail++; $display("FAIL fips_core_key: got %h want %h", core_key, FIPS_KEY); end
      @(negedge clk);
      n_checks++; if (core_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL fips_pulse: got start=%b busy=%b want 0/1", core_start, busy); end
      wait_resp(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fips_resp_wait: got no resp_valid want resp_valid"); end
      $display("job fips: id=%0d data=%h err=%b", resp_id, resp_data, resp_err);
      n_checks++; if (resp_id !== 2'd2) begin n_fail++; $display("FAIL fips_id: got %0d want 2", resp_id); end
      n_checks++; if (resp_data !== FIPS_CT) begin n_fail++; $display("FAIL fips_data: got %h want %h", resp_data, FIPS_CT); end
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL fips_err: got %b want 0", resp_err); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL fips_one_cycle: got %b want 0", resp_valid); end
   endtask

   task automatic test_rotation();
      bit ok;
      int g;
      logic [127:0] e;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_ptr = 0;
      for (int i = 0; i < N; i++) begin
         pt[i] = rand128();
         ky[i] = rand256();
      end
      req_valid  = 4'hF;
      resp_ready = 1'b1;
      core_lat   = 2;
      for (int j = 0; j < 8; j++) begin
         g = j % N;
         wait_ready(ok);
         n_checks++; if (!ok || req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL rot_grant%0d: got %b want %b", j, req_ready, 4'(1 << g)); end
         e = core_fn(pt[g], ky[g]);
         exp_ptr = (g + 1) % N;
         @(negedge clk);
         pt[g] = rand128();
         ky[g] = rand256();
         wait_resp(ok);
         $display("job rot%0d: id=%0d data=%h err=%b", j, resp_id, resp_data, resp_err);
         n_checks++; if (!ok || resp_id !== IW'(g)) begin n_fail++; $display("FAIL rot_id%0d: got %0d want %0d", j, resp_id, g); end
         n_checks++; if (resp_data !== e) begin n_fail++; $display("FAIL rot_data%0d: got %h want %h", j, resp_data, e); end
         @(negedge clk);
         n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rot_idle%0d: got valid=%b busy=%b want 0/0", j, resp_valid, busy); end
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      int g;
      logic [127:0] e;
      g = $urandom_range(0, N - 1);
      pt[g] = rand128();
      ky[g] = rand256();
      req_valid  = 4'(1 << g);
      resp_ready = 1'b0;
      core_lat   = $urandom_range(1, 10);
      wait_ready(ok);
      n_checks++; if (!ok || req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL bp_grant: got %b want %b", req_ready, 4'(1 << g)); end
      e = core_fn(pt[g], ky[g]);
      exp_ptr = (g + 1) % N;
      @(negedge clk);
      req_valid = 4'hF;
      wait_resp(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_resp_wait: got no resp_valid want resp_valid"); end
      $display("job bp: id=%0d data=%h err=%b", resp_id, resp_data, resp_err);
      for (int c = 0; c < 20; c++) begin
         n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", c, resp_valid); end
         n_checks++; if (resp_data !== e || resp_id !== IW'(g)) begin n_fail++; $display("FAIL bp_hold%0d: got %h/%0d want %h/%0d", c, resp_data, resp_id, e, g); end
         #1;
         n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", c, req_ready); end
         inj_done = (c == 10);
         inj_data = rand128();
         @(negedge clk);
      end
      inj_done   = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", resp_valid); end
   endtask

   task automatic test_spurious_idle();
      req_valid = '0;
      inj_data  = rand128();
      inj_done  = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_done: got valid=%b busy=%b want 0/0", resp_valid, busy); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_done2: got valid=%b busy=%b want 0/0", resp_valid, busy); end
   endtask

   task automatic test_random();
      bit ok;
      int g;
      logic [N-1:0] pend;
      logic [127:0] e;
      pend = 4'($urandom_range(1, 15));
      for (int j = 0; j < 24; j++) begin
         pend = pend | 4'($urandom);
         if (pend == '0) pend = 4'b1000;
         req_valid  = pend;
         resp_ready = 1'b0;
         core_lat   = $urandom_range(1, 12);
         wait_ready(ok);
         g = model_pick(pend, exp_ptr);
         n_checks++; if (!ok || req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL rnd_grant%0d: got %b want %b", j, req_ready, 4'(1 << g)); end
         e = core_fn(pt[g], ky[g]);
         exp_ptr = (g + 1) % N;
         @(negedge clk);
         pend[g] = 1'($urandom);
         pt[g] = rand128();
         ky[g] = rand256();
         req_valid = pend;
         wait_resp(ok);
         $display("job rnd%0d: id=%0d data=%h err=%b", j, resp_id, resp_data, resp_err);
         n_checks++; if (!ok || resp_id !== IW'(g) || resp_data !== e) begin n_fail++; $display("FAIL rnd_resp%0d: got %0d/%h want %0d/%h", j, resp_id, resp_data, g, e); end
         n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err%0d: got %b want 0", j, resp_err); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         n_checks++; if (resp_valid !== 1'b1 || resp_data !== e) begin n_fail++; $display("FAIL rnd_hold%0d: got %b/%h want 1/%h", j, resp_valid, resp_data, e); end
         resp_ready = 1'b1;
         @(negedge clk);
         n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drop%0d: got %b want 0", j, resp_valid); end
      end
      req_valid  = '0;
      resp_ready = 1'b1;
      @(negedge clk);
   endtask

`ifdef AES_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int g;
      int c;
      logic [127:0] e;
      // core never answers
      g = $urandom_range(0, N - 1);
      pt[g] = rand128();
      ky[g] = rand256();
      core_hang  = 1'b1;
      req_valid  = 4'(1 << g);
      resp_ready = 1'b0;
      wait_ready(ok);
      exp_ptr = (g + 1) % N;
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b want 1", core_start); end
      c = 0;
      while (!resp_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
      $display("job tmo: id=%0d data=%h err=%b after %0d cycles", resp_id, resp_data, resp_err, c);
      n_checks++; if (c !== TMO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", c, TMO + 1); end
      n_checks++; if (resp_err !== 1'b1 || resp_data !== '0 || resp_id !== IW'(g)) begin n_fail++; $display("FAIL tmo_resp: got %b/%h/%0d want 1/0/%0d", resp_err, resp_data, resp_id, g); end
      resp_ready = 1'b1;
      @(negedge clk);
      core_hang = 1'b0;
      // done coincides with the last watchdog cycle: completion wins
      g = $urandom_range(0, N - 1);
      pt[g] = rand128();
      ky[g] = rand256();
      core_lat   = TMO - 1;
      req_valid  = 4'(1 << g);
      wait_ready(ok);
      e = core_fn(pt[g], ky[g]);
      exp_ptr = (g + 1) % N;
      @(negedge clk);
      req_valid = '0;
      wait_resp(ok);
      $display("job tie: id=%0d data=%h err=%b", resp_id, resp_data, resp_err);
      n_checks++; if (!ok || resp_err !== 1'b0 || resp_data !== e) begin n_fail++; $display("FAIL tmo_tie: got %b/%h want 0/%h", resp_err, resp_data, e); end
      @(negedge clk);
   endtask
`endif

   task automatic test_midreset();
      bit ok;
      int g;
      logic [127:0] e;
      g = $urandom_range(0, N - 2);
      pt[g] = rand128();
      ky[g] = rand256();
      req_valid  = 4'(1 << g);
      resp_ready = 1'b1;
      core_lat   = 20;
      wait_ready(ok);
      n_checks++; if (!ok || req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL mr_grant: got %b want %b", req_ready, 4'(1 << g)); end
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL mr_start: got %b want 1", core_start); end
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || core_start !== 1'b0 || resp_valid !== 1'b0 || req_ready !== '0) begin n_fail++; $display("FAIL mr_ctrl: got busy=%b start=%b valid=%b ready=%b want 0", busy, core_start, resp_valid, req_ready); end
      n_checks++; if (core_data_in !== '0 || core_key !== '0) begin n_fail++; $display("FAIL mr_core_regs: got %h/%h want 0", core_data_in, core_key); end
      n_checks++; if (resp_id !== '0 || resp_data !== '0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL mr_resp_regs: got %0d/%h/%b want 0", resp_id, resp_data, resp_err); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_ptr = 0;
      core_lat = 4;
      req_valid = 4'hF;
      wait_ready(ok);
      g = model_pick(req_valid, exp_ptr);
      n_checks++; if (!ok || req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL mr_regrant: got %b want %b", req_ready, 4'(1 << g)); end
      e = core_fn(pt[g], ky[g]);
      exp_ptr = (g + 1) % N;
      @(negedge clk);
      req_valid = '0;
      wait_resp(ok);
      $display("job mr: id=%0d data=%h err=%b", resp_id, resp_data, resp_err);
      n_checks++; if (!ok || resp_id !== IW'(g) || resp_data !== e) begin n_fail++; $display("FAIL mr_resp: got %0d/%h want %0d/%h", resp_id, resp_data, g, e); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fips();
      test_rotation();
      test_backpressure();
      test_spurious_idle();
      test_random();
`ifdef AES_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
